// File: rtl/adder.sv
// Registered unsigned adder for the shift-and-add multiplier datapath.
// The ripple-carry sum of two WIDTH-bit operands is captured one clock after a qualified request.
module adder #(
    parameter int WIDTH = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Habilita,
    input  logic [WIDTH-1:0] OperandoA,
    input  logic [WIDTH-1:0] OperandoB,
    output logic [WIDTH:0]   Soma,
    output logic             Valido
);

    logic [WIDTH:0] rippleSum;
    logic           carry;

    // Ripple chain of full-adder cells; the carry walks LSB to MSB and ends up as the top sum bit.
    always_comb begin
        rippleSum = '0;
        carry     = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            rippleSum[i] = OperandoA[i] ^ OperandoB[i] ^ carry;
            carry        = (OperandoA[i] & OperandoB[i]) |
                           (OperandoA[i] & carry) |
                           (OperandoB[i] & carry);
        end
        rippleSum[WIDTH] = carry;
    end

    // Soma holds between requests; Valido marks the single cycle after each accepted request.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Soma   <= '0;
            Valido <= 1'b0;
        end else begin
            Valido <= Habilita;
            if (Habilita) begin
                Soma <= rippleSum;
            end
        end
    end

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder: expected sums are queued when requests are driven
// and popped when the registered result shows up one cycle later.
module tb_adder;

    localparam int WIDTH = 4;

    logic             Clock;
    logic             Reset;
    logic             Habilita;
    logic [WIDTH-1:0] OperandoA;
    logic [WIDTH-1:0] OperandoB;
    logic [WIDTH:0]   Soma;
    logic             Valido;

    int vectors    = 0;
    int miscompares = 0;
    int heldSum    = 0;
    int expectQ[$];

    adder #(.WIDTH(WIDTH)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Habilita  (Habilita),
        .OperandoA (OperandoA),
        .OperandoB (OperandoB),
        .Soma      (Soma),
        .Valido    (Valido)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic checkOutput(input string tag, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, got, want, $time);
        end
    endtask

    // Drive one cycle of stimulus on the falling edge, then check the result just after the rising edge.
    task automatic applyStimulus(input logic en, input int a, input int b);
        int want;
        @(negedge Clock);
        Habilita  = en;
        OperandoA = a[WIDTH-1:0];
        OperandoB = b[WIDTH-1:0];
        if (en) expectQ.push_back(a + b);
        @(posedge Clock);
        #1;
        checkOutput("valido", int'(Valido), int'(en));
        if (Valido) begin
            if (expectQ.size() == 0) begin
                checkOutput("queue_empty", 1, 0);
            end else begin
                want = expectQ.pop_front();
                checkOutput($sformatf("soma_%0d+%0d", a, b), int'(Soma), want);
                heldSum = want;
            end
        end else begin
            checkOutput("soma_hold", int'(Soma), heldSum);
        end
    endtask

    initial begin
        Reset     = 1'b1;
        Habilita  = 1'b0;
        OperandoA = '0;
        OperandoB = '0;

        repeat (2) @(posedge Clock);
        #1;
        checkOutput("reset_soma", int'(Soma), 0);
        checkOutput("reset_valido", int'(Valido), 0);
        @(negedge Clock);
        Reset = 1'b0;

        applyStimulus(1'b0, 0, 0);
        applyStimulus(1'b0, 5, 5);

        applyStimulus(1'b1, 1, 2);
        applyStimulus(1'b1, 2, 2);
        applyStimulus(1'b1, 10, 6);
        applyStimulus(1'b1, 15, 15);
        applyStimulus(1'b0, 3, 3);
        applyStimulus(1'b0, 0, 1);

        // Asynchronous reset between edges must clear outputs before the next edge.
        applyStimulus(1'b1, 7, 8);
        #2;
        Reset = 1'b1;
        #1;
        checkOutput("async_soma", int'(Soma), 0);
        checkOutput("async_valido", int'(Valido), 0);
        expectQ.delete();
        heldSum = 0;

        // A request made while reset is held is dropped.
        @(negedge Clock);
        Habilita  = 1'b1;
        OperandoA = 4'd9;
        OperandoB = 4'd4;
        @(posedge Clock);
        #1;
        checkOutput("reset_req_soma", int'(Soma), 0);
        checkOutput("reset_req_valido", int'(Valido), 0);
        @(negedge Clock);
        Reset    = 1'b0;
        Habilita = 1'b0;
        applyStimulus(1'b0, 9, 4);

        for (int a = 0; a < (1 << WIDTH); a++) begin
            for (int b = 0; b < (1 << WIDTH); b++) begin
                applyStimulus(1'b1, a, b);
            end
        end
        applyStimulus(1'b0, 0, 0);

        checkOutput("queue_drained", expectQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
